// File: rtl/fs2d_pkg.sv
// Shared constants and helpers for the single-to-double converter and its scheduler.
// The round-robin pick lives here so the arbiter stays a plain function.
package fs2d_pkg;

  localparam int unsigned FS_W     = 40;
  localparam int unsigned FD_W     = 80;
  localparam int unsigned FS_EXP_W = 10;
  localparam int unsigned FS_MAN_W = 29;
  localparam logic [FS_EXP_W-1:0] EXP_INF = 10'h3FF;

  localparam int unsigned FD_EXP_W = 15;
  localparam int unsigned FD_MAN_W = 64;
  localparam int unsigned FS_BIAS  = 511;
  localparam int unsigned FD_BIAS  = 16383;

  localparam int unsigned FLG_DENORM = 0;
  localparam int unsigned FLG_INF    = 1;
  localparam int unsigned FLG_NAN    = 2;
  localparam int unsigned FLG_W      = 3;

  // Widest requester set the pick function is written for.
  localparam int unsigned RR_MAX = 8;

  typedef logic [FLG_W-1:0] fs_flags_t;

  // Returns the first valid index after `last`, wrapping modulo nreq; nreq means none.
  function automatic int unsigned rr_pick(input logic [RR_MAX-1:0] valid,
                                          input int unsigned last,
                                          input int unsigned nreq);
    int unsigned idx;
    logic        found;
    rr_pick = nreq;
    found   = 1'b0;
    for (int unsigned k = 1; k <= RR_MAX; k++) begin
      idx = last + k;
      if (idx >= nreq) idx = idx - nreq;
      if (!found && (k <= nreq) && valid[idx[2:0]]) begin
        found   = 1'b1;
        rr_pick = idx;
      end
    end
  endfunction

endpackage

// File: rtl/fs2d.sv
// Combinational 40-bit single (1/10/29) to 80-bit double (1/15/64) converter.
// Denormal singles are normalised; they are always representable in the wide format.
module fs2d
  import fs2d_pkg::*;
(
  input  logic [FS_W-1:0]  i_a,
  output logic [FD_W-1:0]  o_d,
  output logic [FLG_W-1:0] o_flags
);

  localparam int unsigned FD_PAD = FD_MAN_W - FS_MAN_W;

  logic                w_sign;
  logic [FS_EXP_W-1:0] w_exp;
  logic [FS_MAN_W-1:0] w_man;
  logic [FS_MAN_W-1:0] w_norm;
  logic                w_exp_zero;
  logic                w_exp_max;
  logic                w_man_zero;
  logic [4:0]          w_lead;
  logic [FD_EXP_W-1:0] w_norm_exp;
  logic [FD_EXP_W-1:0] w_den_exp;

  assign w_sign     = i_a[FS_W-1];
  assign w_exp      = i_a[FS_W-2 -: FS_EXP_W];
  assign w_man      = i_a[FS_MAN_W-1:0];
  assign w_exp_zero = (w_exp == '0);
  assign w_exp_max  = (w_exp == EXP_INF);
  assign w_man_zero = (w_man == '0);

  always_comb begin
    w_lead = '0;
    for (int unsigned i = 0; i < FS_MAN_W; i++) begin
      if (w_man[i]) w_lead = 5'(i);
    end
  end

  // Shifting the leading one just past the top drops the hidden bit.
  assign w_norm     = w_man << (5'(FS_MAN_W) - w_lead);
  assign w_norm_exp = FD_EXP_W'(w_exp) + FD_EXP_W'(FD_BIAS - FS_BIAS);
  assign w_den_exp  = FD_EXP_W'(w_lead) + FD_EXP_W'(FD_BIAS - FS_BIAS - (FS_MAN_W - 1));

  always_comb begin
    o_d = {w_sign, {(FD_W-1){1'b0}}};
    if (w_exp_max) begin
      o_d = {w_sign, {FD_EXP_W{1'b1}}, w_man, {FD_PAD{1'b0}}};
    end else if (!w_exp_zero) begin
      o_d = {w_sign, w_norm_exp, w_man, {FD_PAD{1'b0}}};
    end else if (!w_man_zero) begin
      o_d = {w_sign, w_den_exp, w_norm, {FD_PAD{1'b0}}};
    end
  end

  assign o_flags[FLG_DENORM] = w_exp_zero & ~w_man_zero;
  assign o_flags[FLG_INF]    = w_exp_max & w_man_zero;
  assign o_flags[FLG_NAN]    = w_exp_max & ~w_man_zero;

endmodule

// File: rtl/fs2d_sched.sv
// Round-robin front end sharing one fs2d converter among NREQ requesters through a
// two-stage registered pipeline with a tagged, backpressured response bus.
module fs2d_sched
  import fs2d_pkg::*;
#(
  parameter int unsigned NREQ = 4,
  parameter int unsigned IDW  = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ*FS_W-1:0] req_a,
  output logic [NREQ-1:0]      req_ready,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [IDW-1:0]       rsp_id,
  output logic [FD_W-1:0]      rsp_o,
  output logic [FLG_W-1:0]     rsp_flags,
  output logic                 busy
);

  logic              r_s1_v;
  logic [FS_W-1:0]   r_s1_a;
  logic [IDW-1:0]    r_s1_id;
  logic              r_s2_v;
  logic [FD_W-1:0]   r_s2_o;
  logic [IDW-1:0]    r_s2_id;
  fs_flags_t         r_s2_flags;
  logic [IDW-1:0]    r_rr;

  logic [RR_MAX-1:0] w_valid_ext;
  int unsigned       w_pick;
  logic              w_found;
  logic              w_adv1;
  logic              w_adv2;
  logic              w_grant;
  logic [IDW-1:0]    w_gnt_id;
  logic [FS_W-1:0]   w_gnt_a;
  logic [FD_W-1:0]   w_conv_o;
  fs_flags_t         w_conv_flags;

  assign w_adv2 = ~r_s2_v | rsp_ready;
  assign w_adv1 = ~r_s1_v | w_adv2;

  always_comb begin
    w_valid_ext = '0;
    w_valid_ext[NREQ-1:0] = req_valid;
  end

  assign w_pick   = rr_pick(w_valid_ext, 32'(r_rr), NREQ);
  assign w_found  = (w_pick < NREQ);
  assign w_gnt_id = w_pick[IDW-1:0];
  // Reset and flush both suppress grants so nothing transfers into a clearing pipe.
  assign w_grant  = rst_n & ~flush & w_adv1 & w_found;

  always_comb begin
    req_ready = '0;
    w_gnt_a   = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (w_pick == i) begin
        req_ready[i] = w_grant;
        w_gnt_a      = req_a[i*FS_W +: FS_W];
      end
    end
  end

  fs2d u_fs2d (
    .i_a     (r_s1_a),
    .o_d     (w_conv_o),
    .o_flags (w_conv_flags)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_s1_v     <= 1'b0;
      r_s1_a     <= '0;
      r_s1_id    <= '0;
      r_s2_v     <= 1'b0;
      r_s2_o     <= '0;
      r_s2_id    <= '0;
      r_s2_flags <= '0;
      r_rr       <= IDW'(NREQ - 1);
    end else if (flush) begin
      r_s1_v <= 1'b0;
      r_s2_v <= 1'b0;
    end else begin
      if (w_adv2) begin
        r_s2_v <= r_s1_v;
        // Payload only moves with a real operand so an idle bus keeps its last value.
        if (r_s1_v) begin
          r_s2_o     <= w_conv_o;
          r_s2_id    <= r_s1_id;
          r_s2_flags <= w_conv_flags;
        end
      end
      if (w_adv1) begin
        r_s1_v <= w_grant;
        if (w_grant) begin
          r_s1_a  <= w_gnt_a;
          r_s1_id <= w_gnt_id;
          r_rr    <= w_gnt_id;
        end
      end
    end
  end

  assign rsp_valid = r_s2_v;
  assign rsp_id    = r_s2_id;
  assign rsp_o     = r_s2_o;
  assign rsp_flags = r_s2_flags;
  assign busy      = r_s1_v | r_s2_v;

endmodule
